// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator.
// Imported by the accumulator stage and by integration wrappers.
package product_accumulator_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums a programmed number of multiplier products into a wide accumulator.
// Result and sticky carry-out flag leave on a valid/ready output.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [PROD_W-1:0] product,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] remaining;
    logic [ACC_W:0]   sum_ext;
    logic             beat;

    // One extra bit on the adder catches the carry leaving the accumulator.
    always_comb begin
        sum_ext = {1'b0, acc}
                + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
        beat    = (state == ACCUM) && in_valid;
    end

    // Handshake outputs are pure decodes of the state register.
    always_comb begin
        in_ready  = (state == ACCUM);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        acc_out   = acc;
        overflow  = ovf;
    end

    // Control FSM, beat down-counter and accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        remaining <= len;
                        state     <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc       <= sum_ext[ACC_W-1:0];
                        ovf       <= ovf | sum_ext[ACC_W];
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomised checks of product_accumulator at two widths.
// Reference: whole-run totals reduced modulo 2^ACC_W.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic [7:0]  product;
    logic        in_valid;
    logic        out_ready;

    logic        ir16, ov_v16, ovf16, busy16;
    logic [15:0] acc16;
    logic        ir8, ov_v8, ovf8, busy8;
    logic [7:0]  acc8;

    int n_asrt = 0;
    int n_fail = 0;
    int prods[16];
    int exp16, exp8;
    bit eov16, eov8;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .product(product), .in_valid(in_valid), .in_ready(ir16),
        .acc_out(acc16), .overflow(ovf16), .out_valid(ov_v16),
        .out_ready(out_ready), .busy(busy16)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .product(product), .in_valid(in_valid), .in_ready(ir8),
        .acc_out(acc8), .overflow(ovf8), .out_valid(ov_v8),
        .out_ready(out_ready), .busy(busy8)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: the sum of all terms; carry ever left W bits iff total >= 2^W.
    task automatic model(input int n);
        int total = 0;
        for (int i = 0; i < n; i++) total += prods[i];
        exp16 = total % 65536;
        eov16 = (total >= 65536);
        exp8  = total % 256;
        eov8  = (total >= 256);
    endtask

    task automatic chk_result(input string tag);
        chk({tag, " out_valid16"}, int'(ov_v16), 1);
        chk({tag, " out_valid8"}, int'(ov_v8), 1);
        chk({tag, " in_ready16"}, int'(ir16), 0);
        chk({tag, " busy16"}, int'(busy16), 1);
        chk({tag, " acc16"}, int'(acc16), exp16);
        chk({tag, " ovf16"}, int'(ovf16), int'(eov16));
        chk({tag, " acc8"}, int'(acc8), exp8);
        chk({tag, " ovf8"}, int'(ovf8), int'(eov8));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " idle out_valid16"}, int'(ov_v16), 0);
        chk({tag, " idle busy16"}, int'(busy16), 0);
        chk({tag, " idle busy8"}, int'(busy8), 0);
        chk({tag, " idle in_ready16"}, int'(ir16), 0);
    endtask

    // mode: 0 back-to-back, 1 alternate bubbles, 2 random bubbles.
    // hold: cycles of out_ready=0 in DONE. noisy: spurious start pulses.
    task automatic run(input string tag, input int n, input int mode,
                       input int hold, input bit noisy);
        int idx = 0;
        int cyc = 0;
        bit v;
        model(n);
        @(negedge clk);
        start = 1'b1;
        len   = 4'(n);
        @(negedge clk);
        start = 1'b0;
        while (idx < n) begin
            if (cyc > 100) begin
                chk({tag, " beat timeout"}, idx, n);
                break;
            end
            chk({tag, " in_ready"}, int'(ir16 & ir8), 1);
            chk({tag, " early out_valid"}, int'(ov_v16 | ov_v8), 0);
            case (mode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            product  = 8'(v ? prods[idx] : $urandom_range(0, 255));
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                len   = 4'd7;
            end
            @(negedge clk);
            if (v) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        product  = 8'($urandom_range(0, 255));
        chk_result(tag);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            if (noisy) begin
                start = 1'b1;
                len   = 4'd7;
            end
            @(negedge clk);
            chk_result({tag, " hold"});
        end
        out_ready = 1'b1;
        if (noisy) start = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk_idle(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        product   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset acc16", int'(acc16), 0);
        chk("reset ovf16", int'(ovf16), 0);
        chk("reset acc8", int'(acc8), 0);
        chk_idle("reset");
        rst_n = 1'b1;

        prods[0:4] = '{3, 99, 45, 104, 30};
        run("normal", 5, 0, 0, 1'b0);
        run("bubbles", 5, 1, 0, 1'b0);

        prods[0:1] = '{225, 45};
        run("overflow", 2, 0, 0, 1'b0);
        chk("overflow acc8 const", int'(acc8), 14);
        prods[0] = 7;
        run("after_ovf", 1, 0, 0, 1'b0);
        chk("after_ovf acc8 const", int'(acc8), 7);

        run("empty", 0, 0, 5, 1'b0);

        prods[0:2] = '{17, 200, 64};
        run("ignored_start", 3, 0, 2, 1'b1);

        prods[0:3] = '{11, 22, 33, 44};
        @(negedge clk);
        start = 1'b1;
        len   = 4'd4;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        product  = 8'd11;
        @(negedge clk);
        product  = 8'd22;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midreset acc16", int'(acc16), 0);
        chk("midreset acc8", int'(acc8), 0);
        chk("midreset ovf8", int'(ovf8), 0);
        chk_idle("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post reset quiet", int'(ov_v16 | ov_v8 | busy16), 0);
        end
        prods[0] = 50;
        run("fresh", 1, 0, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            int n = $urandom_range(1, 15);
            for (int i = 0; i < n; i++) prods[i] = $urandom_range(0, 255);
            run("random", n, 2, $urandom_range(0, 3), 1'(r % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
